icache_refill_responder: RTL and testbench



---
 rtl/icache_refill_responder_pkg.sv | 28 ++
 rtl/icache_refill_responder_if.sv | 47 ++++
 rtl/icache_refill_responder_req_fifo.sv | 59 +++++
 rtl/icache_refill_responder.sv | 153 +++++++++++++++
 tb/tb_icache_refill_responder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_refill_responder_pkg.sv
// Shared types and geometry helpers for the icache refill responder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package icache_refill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } refill_state_e;

    // Number of memory beats that make up one cache line.
    function automatic int nb_beats(input int fetch_data_width, input int mem_data_width);
        return fetch_data_width / mem_data_width;
    endfunction

    // Byte-offset bits inside one cache line.
    function automatic int line_ofs(input int fetch_data_width);
        return $clog2(fetch_data_width / 8);
    endfunction

    // Byte-offset bits inside one memory beat.
    function automatic int beat_ofs(input int mem_data_width);
        return $clog2(mem_data_width / 8);
    endfunction

endpackage

// File: rtl/icache_refill_responder_if.sv
// Bundle of the refill (cache-facing) and beat memory (interconnect-facing) ports.
// Latency: n/a (wiring only); stat signals exist only with ICACHE_REFILL_STAT_EN.
// Backpressure: refill side via gnt, memory side via mem_gnt; responses never stall.
interface icache_refill_responder_if #(
    parameter int FETCH_ADDR_WIDTH = 32,
    parameter int FETCH_DATA_WIDTH = 128,
    parameter int MEM_DATA_WIDTH   = 32
);
    logic                        refill_req_i;
    logic                        refill_gnt_o;
    logic [FETCH_ADDR_WIDTH-1:0] refill_addr_i;
    logic                        refill_r_valid_o;
    logic [FETCH_DATA_WIDTH-1:0] refill_r_data_o;
    logic                        mem_req_o;
    logic                        mem_gnt_i;
    logic [FETCH_ADDR_WIDTH-1:0] mem_addr_o;
    logic                        mem_r_valid_i;
    logic [MEM_DATA_WIDTH-1:0]   mem_r_data_i;
    logic                        busy_o;
`ifdef ICACHE_REFILL_STAT_EN
    logic                        stat_clear_i;
    logic                        stat_enable_i;
    logic [31:0]                 stat_line_count_o;
    logic [31:0]                 stat_wait_count_o;
`endif

    // Responder side.
    modport slave (
        input  refill_req_i, refill_addr_i, mem_gnt_i, mem_r_valid_i, mem_r_data_i,
`ifdef ICACHE_REFILL_STAT_EN
        input  stat_clear_i, stat_enable_i,
        output stat_line_count_o, stat_wait_count_o,
`endif
        output refill_gnt_o, refill_r_valid_o, refill_r_data_o, mem_req_o, mem_addr_o, busy_o
    );

    // Cache + memory side driving the responder.
    modport master (
        output refill_req_i, refill_addr_i, mem_gnt_i, mem_r_valid_i, mem_r_data_i,
`ifdef ICACHE_REFILL_STAT_EN
        output stat_clear_i, stat_enable_i,
        input  stat_line_count_o, stat_wait_count_o,
`endif
        input  refill_gnt_o, refill_r_valid_o, refill_r_data_o, mem_req_o, mem_addr_o, busy_o
    );

endinterface

// File: rtl/icache_refill_responder_req_fifo.sv
// Small FIFO holding pending line-refill addresses.
// Latency: push visible at head one cycle later; pop takes effect at the clock edge.
// Backpressure: full blocks pushes (push while full is ignored); pop while empty is ignored.
module refill_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNTW-1:0]  count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CNTW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNTW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and occupancy, wrapping at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

endmodule

// File: rtl/icache_refill_responder.sv
// Refill responder: queues line requests, fetches each line as NB_BEATS memory beats, returns it whole.
// Latency: first mem_req 2 cycles after grant; r_valid 7 cycles after grant for 4 beats at 1-cycle memory.
// Backpressure: refill gnt = !fifo_full; mem_gnt stalls beat issue; r_valid pulse is never stalled. Optional stats: ICACHE_REFILL_STAT_EN.
module icache_refill_responder
    import icache_refill_pkg::*;
#(
    parameter int FETCH_ADDR_WIDTH = 32,
    parameter int FETCH_DATA_WIDTH = 128,
    parameter int MEM_DATA_WIDTH   = 32,
    parameter int REQ_FIFO_DEPTH   = 2
) (
    input logic                      clk,
    input logic                      rst,
    icache_refill_responder_if.slave bus
);
    localparam int NB_BEATS = nb_beats(FETCH_DATA_WIDTH, MEM_DATA_WIDTH);
    localparam int LINE_OFS = line_ofs(FETCH_DATA_WIDTH);
    localparam int BEAT_OFS = beat_ofs(MEM_DATA_WIDTH);
    localparam int CW       = $clog2(NB_BEATS) + 1;
    localparam int FCW      = $clog2(REQ_FIFO_DEPTH + 1);
    localparam logic [FETCH_ADDR_WIDTH-1:0] LINE_MASK =
        ~((FETCH_ADDR_WIDTH'(1) << LINE_OFS) - FETCH_ADDR_WIDTH'(1));

    refill_state_e               state_q, state_d;
    logic [CW-1:0]               issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]               rx_cnt_q, rx_cnt_d;
    logic [FETCH_DATA_WIDTH-1:0] data_q;
    logic [FETCH_ADDR_WIDTH-1:0] head_addr;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [FCW-1:0]              fifo_count;
    logic                        push;
    logic                        pop;
    logic                        collect;

    // Gnt is held low during reset and is independent of the request itself.
    assign bus.refill_gnt_o = !rst && !fifo_full;
    assign push             = bus.refill_req_i && bus.refill_gnt_o;
    assign collect          = ((state_q == ISSUE) || (state_q == DRAIN)) && bus.mem_r_valid_i;
    assign bus.busy_o       = !fifo_empty || (state_q != IDLE);
    assign bus.refill_r_data_o = data_q;

    refill_req_fifo #(
        .DEPTH (REQ_FIFO_DEPTH),
        .WIDTH (FETCH_ADDR_WIDTH),
        .CNTW  (FCW)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (bus.refill_addr_i & LINE_MASK),
        .head      (head_addr),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state, beat counters and handshake outputs.
    always_comb begin
        state_d              = state_q;
        issue_cnt_d          = issue_cnt_q;
        rx_cnt_d             = rx_cnt_q + CW'(collect);
        pop                  = 1'b0;
        bus.mem_req_o        = 1'b0;
        bus.mem_addr_o       = '0;
        bus.refill_r_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                issue_cnt_d = '0;
                rx_cnt_d    = '0;
                if (!fifo_empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = head_addr | (FETCH_ADDR_WIDTH'(issue_cnt_q) << BEAT_OFS);
                if (bus.mem_gnt_i) begin
                    issue_cnt_d = issue_cnt_q + CW'(1);
                    if (issue_cnt_q == CW'(NB_BEATS - 1)) begin
                        // Zero-latency memory can finish the line on its last grant.
                        state_d = (rx_cnt_d == CW'(NB_BEATS)) ? RESP : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rx_cnt_d == CW'(NB_BEATS)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.refill_r_valid_o = 1'b1;
                pop                  = 1'b1;
                issue_cnt_d          = '0;
                rx_cnt_d             = '0;
                // Another entry remains after this pop: stream straight into the next line.
                state_d = ((fifo_count > FCW'(1)) || push) ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            rx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end

    // Line assembly: each arriving beat lands in the slice selected by rx_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (collect) begin
            for (int b = 0; b < NB_BEATS; b++) begin
                if (rx_cnt_q == CW'(b)) begin
                    data_q[b*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= bus.mem_r_data_i;
                end
            end
        end
    end

`ifdef ICACHE_REFILL_STAT_EN
    logic [31:0] line_cnt_q;
    logic [31:0] wait_cnt_q;

    assign bus.stat_line_count_o = line_cnt_q;
    assign bus.stat_wait_count_o = wait_cnt_q;

    // Saturating line and wait counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || bus.stat_clear_i) begin
            line_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else if (bus.stat_enable_i) begin
            if ((state_q == RESP) && (line_cnt_q != '1)) begin
                line_cnt_q <= line_cnt_q + 32'd1;
            end
            if (((state_q == ISSUE) || (state_q == DRAIN)) && !fifo_empty && (wait_cnt_q != '1)) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_refill_responder.sv
// Scoreboard bench for icache_refill_responder: expected beat addresses and lines queued at issue, checked by a monitor.
// Latency: checks 7-cycle (1-cycle memory) and 6-cycle (zero-latency memory) grant-to-r_valid.
// Backpressure: covers mem_gnt stalls, FIFO full, and reset mid-line; stats with ICACHE_REFILL_STAT_EN.
module tb_icache_refill_responder;
    localparam int FAW = 32;
    localparam int FDW = 128;
    localparam int MDW = 32;
    localparam int NB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_refill_responder_if #(.FETCH_ADDR_WIDTH(FAW), .FETCH_DATA_WIDTH(FDW), .MEM_DATA_WIDTH(MDW)) bus();

    icache_refill_responder #(
        .FETCH_ADDR_WIDTH (FAW),
        .FETCH_DATA_WIDTH (FDW),
        .MEM_DATA_WIDTH   (MDW),
        .REQ_FIFO_DEPTH   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int beats_total = 0;
    int rv_count    = 0;
    int last_rv_cyc = -100;
    int gnt_cyc     = 0;

    logic [FAW-1:0] exp_addr [$];
    logic [FDW-1:0] exp_line [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: always or stall-controlled grant, 1-cycle or zero-latency response.
    logic        gnt_en   = 1'b1;
    logic        zero_lat = 1'b0;
    logic        rv_q     = 1'b0;
    logic [31:0] rd_q     = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            rv_q <= 1'b0;
        end else begin
            rv_q <= bus.mem_req_o && gnt_en && !zero_lat;
            rd_q <= mem_word(bus.mem_addr_o);
        end
    end

    assign bus.mem_gnt_i     = gnt_en;
    assign bus.mem_r_valid_i = zero_lat ? (bus.mem_req_o && gnt_en) : rv_q;
    assign bus.mem_r_data_i  = zero_lat ? mem_word(bus.mem_addr_o) : rd_q;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        logic [31:0]  base;
        logic [127:0] line;
        base = a & 32'hFFFF_FFF0;
        for (int b = 0; b < NB; b++) begin
            exp_addr.push_back(base + 32'(4 * b));
            line[b*32 +: 32] = mem_word(base + 32'(4 * b));
        end
        exp_line.push_back(line);
    endtask

    task automatic send_req(input logic [31:0] a, input logic exp_gnt);
        @(negedge clk);
        bus.refill_req_i  = 1'b1;
        bus.refill_addr_i = a;
        #1;
        check("refill_gnt", 128'(bus.refill_gnt_o), 128'(exp_gnt));
        if (bus.refill_gnt_o) begin
            push_exp(a);
            gnt_cyc = cyc;
        end
    endtask

    task automatic idle_req();
        @(negedge clk);
        bus.refill_req_i = 1'b0;
    endtask

    task automatic wait_rv(input int target);
        for (int i = 0; i < 200 && rv_count < target; i++) @(negedge clk);
        if (rv_count < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_rv: timeout, got %0d lines expected %0d", rv_count, target);
        end
    endtask

    // Monitor: pops the scoreboard on each beat handshake and each line response.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (bus.mem_req_o && bus.mem_gnt_i) begin
                    beats_total++;
                    if (exp_addr.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mem_addr: unexpected beat request %h", bus.mem_addr_o);
                    end else begin
                        check("mem_addr", 128'(bus.mem_addr_o), 128'(exp_addr.pop_front()));
                    end
                end
                if (bus.refill_r_valid_o) begin
                    rv_count++;
                    last_rv_cyc = cyc;
                    if (exp_line.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL line_data: unexpected r_valid data %h", bus.refill_r_data_o);
                    end else begin
                        check("line_data", bus.refill_r_data_o, exp_line.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int  b0;
        int  r0;
        int  g0;
        logic got;
        bus.refill_req_i  = 1'b0;
        bus.refill_addr_i = '0;
`ifdef ICACHE_REFILL_STAT_EN
        bus.stat_clear_i  = 1'b0;
        bus.stat_enable_i = 1'b1;
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", 128'(bus.refill_gnt_o), 128'(0));
        check("rst_r_valid", 128'(bus.refill_r_valid_o), 128'(0));
        check("rst_mem_req", 128'(bus.mem_req_o), 128'(0));
        check("rst_mem_addr", 128'(bus.mem_addr_o), 128'(0));
        check("rst_busy", 128'(bus.busy_o), 128'(0));
        check("rst_r_data", bus.refill_r_data_o, 128'(0));
`ifdef ICACHE_REFILL_STAT_EN
        check("rst_stat_lines", 128'(bus.stat_line_count_o), 128'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("gnt_after_rst", 128'(bus.refill_gnt_o), 128'(1));

        // Single line, 1-cycle memory.
        send_req(32'h1C00_0014, 1'b1);
        g0 = gnt_cyc;
        idle_req();
        wait_rv(1);
        check("single_latency", 128'(last_rv_cyc - g0), 128'(7));
        #1;
        check("single_data_hold", bus.refill_r_data_o, 128'hC2AD001C_C2AD0018_C2AD0014_C2AD0010);
        check("single_busy_idle", 128'(bus.busy_o), 128'(0));

        // Beat grant stalled for 5 cycles after two beats.
        b0 = beats_total;
        r0 = rv_count;
        send_req(32'h2000_004C, 1'b1);
        idle_req();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.mem_req_o && beats_total == b0 + 2) break;
        end
        gnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_mem_req", 128'(bus.mem_req_o), 128'(1));
            check("stall_mem_addr", 128'(bus.mem_addr_o), 128'(32'h2000_0048));
            @(negedge clk);
            #1;
        end
        gnt_en = 1'b1;
        wait_rv(r0 + 1);

        // FIFO full: gnt 1,1,0 then reopens the cycle after the first response.
`ifdef ICACHE_REFILL_STAT_EN
        @(negedge clk);
        bus.stat_clear_i = 1'b1;
        @(negedge clk);
        bus.stat_clear_i = 1'b0;
`endif
        r0 = rv_count;
        send_req(32'h3000_0000, 1'b1);
        send_req(32'h3000_0104, 1'b1);
        send_req(32'h3000_0208, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (bus.refill_gnt_o) begin
                push_exp(32'h3000_0208);
                check("gnt_reopen_cycle", 128'(cyc), 128'(last_rv_cyc + 1));
                check("gnt_reopen_lines", 128'(rv_count), 128'(r0 + 1));
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL gnt_reopen: gnt never returned to 1");
        end
        idle_req();
        wait_rv(r0 + 3);
`ifdef ICACHE_REFILL_STAT_EN
        @(negedge clk);
        #1;
        check("stat_lines", 128'(bus.stat_line_count_o), 128'(3));
        check("stat_wait", 128'(bus.stat_wait_count_o), 128'(15));
        @(negedge clk);
        bus.stat_clear_i = 1'b1;
        @(negedge clk);
        bus.stat_clear_i = 1'b0;
        #1;
        check("stat_lines_clr", 128'(bus.stat_line_count_o), 128'(0));
        check("stat_wait_clr", 128'(bus.stat_wait_count_o), 128'(0));
        bus.stat_enable_i = 1'b0;
`endif

        // Zero-latency memory: ISSUE goes straight to RESP.
        zero_lat = 1'b1;
        r0 = rv_count;
        send_req(32'h5A5A_0030, 1'b1);
        g0 = gnt_cyc;
        idle_req();
        wait_rv(r0 + 1);
        check("zero_lat_latency", 128'(last_rv_cyc - g0), 128'(6));
        zero_lat = 1'b0;
`ifdef ICACHE_REFILL_STAT_EN
        check("stat_disabled", 128'(bus.stat_line_count_o), 128'(0));
        bus.stat_enable_i = 1'b1;
`endif

        // Reset after two beats: line abandoned, then a fresh line served.
        b0 = beats_total;
        send_req(32'h4000_0020, 1'b1);
        idle_req();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (beats_total == b0 + 2) break;
        end
        rst = 1'b1;
        exp_addr.delete();
        exp_line.delete();
        r0 = rv_count;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_busy", 128'(bus.busy_o), 128'(0));
        check("post_rst_gnt", 128'(bus.refill_gnt_o), 128'(1));
        check("post_rst_r_valid", 128'(bus.refill_r_valid_o), 128'(0));
        repeat (10) @(negedge clk);
        check("post_rst_no_line", 128'(rv_count), 128'(r0));
        send_req(32'h4000_0100, 1'b1);
        idle_req();
        wait_rv(r0 + 1);

        repeat (5) @(negedge clk);
        check("sb_lines_left", 128'(exp_line.size()), 128'(0));
        check("sb_addrs_left", 128'(exp_addr.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
